// File: rtl/s_protocol_adapter_egress.sv
// Transmit-side packet adapter from the MoSAIC fabric to open-nic-shell.
// Buffers AXI-Stream beats, releases whole or cut-through packets, and flags TKEEP violations.
module s_protocol_adapter_egress #(
    parameter int DEPTH        = 16,
    parameter int BP_THRESHOLD = 12,
    parameter int STORE_FWD    = 1
) (
    input  logic        clk_line,
    input  logic        rst,
    input  logic        backpressure_in,
    output logic        backpressure_out,
    input  logic        stream_in_TLAST,
    input  logic        stream_in_TVALID,
    output logic        stream_in_TREADY,
    input  logic [31:0] stream_in_TDATA,
    input  logic [3:0]  stream_in_TKEEP,
    output logic        stream_out_TLAST,
    output logic        stream_out_TVALID,
    input  logic        stream_out_TREADY,
    output logic [31:0] stream_out_TDATA,
    output logic [3:0]  stream_out_TKEEP,
    output logic        protocol_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [36:0]   mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] pktCount_q, pktCount_d;
    logic          bp_q, bp_d;
    logic          err_q, err_d;
    logic [0:0]    state_q, state_d;

    logic          full, empty, wrEn, rdEn, keepBad, releasable;
    logic [36:0]   head;

    assign full  = (occ_q == CW'(DEPTH));
    assign empty = (occ_q == '0);
    assign head  = mem_q[rdPtr_q];
    assign wrEn  = stream_in_TVALID && !full;
    assign rdEn  = (state_q == SEND) && !empty && stream_out_TREADY;

    assign stream_in_TREADY  = !full;
    assign stream_out_TVALID = (state_q == SEND) && !empty;
    assign stream_out_TLAST  = head[36];
    assign stream_out_TKEEP  = head[35:32];
    assign stream_out_TDATA  = head[31:0];
    assign backpressure_out  = bp_q;
    assign protocol_err      = err_q;

    // Non-last beats must be full words; a last beat may only be a contiguous low-byte prefix.
    always_comb begin
        keepBad = 1'b0;
        if (!stream_in_TLAST) begin
            keepBad = (stream_in_TKEEP != 4'hF);
        end else begin
            case (stream_in_TKEEP)
                4'h1, 4'h3, 4'h7, 4'hF: keepBad = 1'b0;
                default:                keepBad = 1'b1;
            endcase
        end
    end

    // A full FIFO with no complete packet must still drain, otherwise an oversize packet deadlocks.
    always_comb begin
        releasable = 1'b0;
        if (STORE_FWD != 0) begin
            releasable = (pktCount_q != '0) || full;
        end else begin
            releasable = !empty;
        end
    end

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        occ_d      = occ_q;
        pktCount_d = pktCount_q;
        state_d    = state_q;
        if (wrEn) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (rdEn) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({wrEn, rdEn})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
        case ({wrEn && stream_in_TLAST, rdEn && head[36]})
            2'b10:   pktCount_d = pktCount_q + CW'(1);
            2'b01:   pktCount_d = pktCount_q - CW'(1);
            default: pktCount_d = pktCount_q;
        endcase
        bp_d  = (occ_d >= CW'(BP_THRESHOLD));
        err_d = err_q || (wrEn && keepBad);
        case (state_q)
            IDLE: begin
                if (!backpressure_in && releasable) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (rdEn && head[36]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_line) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            occ_q      <= '0;
            pktCount_q <= '0;
            bp_q       <= 1'b0;
            err_q      <= 1'b0;
            state_q    <= IDLE;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            occ_q      <= occ_d;
            pktCount_q <= pktCount_d;
            bp_q       <= bp_d;
            err_q      <= err_d;
            state_q    <= state_d;
        end
    end

    always_ff @(posedge clk_line) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= {stream_in_TLAST, stream_in_TKEEP, stream_in_TDATA};
        end
    end

endmodule

// File: tb/tb_s_protocol_adapter_egress.sv
// Bench for s_protocol_adapter_egress: accepted beats go into a scoreboard queue,
// and every beat the shell takes is popped and compared in order.
module tb_s_protocol_adapter_egress;

    logic        clk_line = 1'b0;
    logic        rst = 1'b1;
    logic        backpressure_in = 1'b0;
    logic        backpressure_out;
    logic        stream_in_TLAST = 1'b0;
    logic        stream_in_TVALID = 1'b0;
    logic        stream_in_TREADY;
    logic [31:0] stream_in_TDATA = '0;
    logic [3:0]  stream_in_TKEEP = '0;
    logic        stream_out_TLAST;
    logic        stream_out_TVALID;
    logic        stream_out_TREADY = 1'b1;
    logic [31:0] stream_out_TDATA;
    logic [3:0]  stream_out_TKEEP;
    logic        protocol_err;

    int          nCompared = 0;
    int          nMismatched = 0;
    int          outBeats = 0;
    int          tbOcc = 0;
    logic [36:0] sbQueue [$];

    s_protocol_adapter_egress #(
        .DEPTH(16),
        .BP_THRESHOLD(12),
        .STORE_FWD(1)
    ) dut (
        .clk_line(clk_line),
        .rst(rst),
        .backpressure_in(backpressure_in),
        .backpressure_out(backpressure_out),
        .stream_in_TLAST(stream_in_TLAST),
        .stream_in_TVALID(stream_in_TVALID),
        .stream_in_TREADY(stream_in_TREADY),
        .stream_in_TDATA(stream_in_TDATA),
        .stream_in_TKEEP(stream_in_TKEEP),
        .stream_out_TLAST(stream_out_TLAST),
        .stream_out_TVALID(stream_out_TVALID),
        .stream_out_TREADY(stream_out_TREADY),
        .stream_out_TDATA(stream_out_TDATA),
        .stream_out_TKEEP(stream_out_TKEEP),
        .protocol_err(protocol_err)
    );

    always #5 clk_line = ~clk_line;

    // Output handshakes are judged half a cycle before the edge that completes them.
    always @(negedge clk_line) begin
        logic [36:0] exp;
        if (!rst && stream_out_TVALID === 1'b1 && stream_out_TREADY === 1'b1) begin
            outBeats++;
            tbOcc--;
            nCompared++;
            if (sbQueue.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL scoreboard_extra: got beat %h, expected no beat",
                         {stream_out_TLAST, stream_out_TKEEP, stream_out_TDATA});
            end else begin
                exp = sbQueue.pop_front();
                if ({stream_out_TLAST, stream_out_TKEEP, stream_out_TDATA} !== exp) begin
                    nMismatched++;
                    $display("[TB] FAIL scoreboard_beat: got %h expected %h",
                             {stream_out_TLAST, stream_out_TKEEP, stream_out_TDATA}, exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [31:0] data, input logic [3:0] keep, input logic last);
        bit accepted = 1'b0;
        stream_in_TDATA  = data;
        stream_in_TKEEP  = keep;
        stream_in_TLAST  = last;
        stream_in_TVALID = 1'b1;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clk_line);
            if (stream_in_TREADY === 1'b1) begin
                accepted = 1'b1;
                sbQueue.push_back({last, keep, data});
                tbOcc++;
            end
            @(posedge clk_line);
            #1;
        end
        stream_in_TVALID = 1'b0;
        if (!accepted) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL input_accept: got no TREADY in 200 cycles, expected beat %h accepted", data);
        end
    endtask

    task automatic waitDrain(input int maxCycles, output bit drained);
        drained = 1'b0;
        for (int c = 0; c < maxCycles; c++) begin
            @(posedge clk_line);
            #1;
            if (sbQueue.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        @(posedge clk_line);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        sbQueue.delete();
        tbOcc = 0;
        @(posedge clk_line);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk_line);
        #1;
        rst = 1'b0;
        nCompared++;
        if (stream_out_TVALID !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_tvalid: got %b expected 0", stream_out_TVALID);
        end
        nCompared++;
        if (stream_in_TREADY !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_tready: got %b expected 1", stream_in_TREADY);
        end
        nCompared++;
        if (backpressure_out !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_bp: got %b expected 0", backpressure_out);
        end
        nCompared++;
        if (protocol_err !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_err: got %b expected 0", protocol_err);
        end
    endtask

    task automatic test_store_fwd();
        logic expValid [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        stream_out_TREADY = 1'b1;
        applyStimulus(32'hA000_0000, 4'hF, 1'b0);
        applyStimulus(32'hA000_0001, 4'hF, 1'b0);
        applyStimulus(32'hA000_0002, 4'h3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(posedge clk_line);
                #1;
            end
            nCompared++;
            if (stream_out_TVALID !== expValid[k]) begin
                nMismatched++;
                $display("[TB] FAIL sf_latency_%0d: got TVALID %b expected %b", k, stream_out_TVALID, expValid[k]);
            end
        end
        nCompared++;
        if (sbQueue.size() != 0 || protocol_err !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL sf_done: got %0d pending err %b expected 0 pending err 0", sbQueue.size(), protocol_err);
        end
    endtask

    task automatic test_backpressure_fill();
        stream_out_TREADY = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(32'h1000_0000 + i, 4'hF, (i == 15));
            nCompared++;
            if (backpressure_out !== (tbOcc >= 12)) begin
                nMismatched++;
                $display("[TB] FAIL fill_bp_w%0d: got %b expected %b", i + 1, backpressure_out, (tbOcc >= 12));
            end
        end
        for (int k = 0; k < 2; k++) begin
            nCompared++;
            if (stream_in_TREADY !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL full_tready_%0d: got %b expected 0", k, stream_in_TREADY);
            end
            @(posedge clk_line);
            #1;
        end
        stream_out_TREADY = 1'b1;
        for (int c = 0; c < 40 && tbOcc > 0; c++) begin
            @(posedge clk_line);
            #1;
            nCompared++;
            if (backpressure_out !== (tbOcc >= 12)) begin
                nMismatched++;
                $display("[TB] FAIL drain_bp_occ%0d: got %b expected %b", tbOcc, backpressure_out, (tbOcc >= 12));
            end
        end
        @(posedge clk_line);
        #1;
        nCompared++;
        if (sbQueue.size() != 0 || stream_in_TREADY !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL fill_drained: got %0d pending tready %b expected 0 pending tready 1", sbQueue.size(), stream_in_TREADY);
        end
    endtask

    task automatic test_oversize();
        int  base = outBeats;
        bit  drained;
        stream_out_TREADY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(32'h2000_0000 + i, 4'hF, (i == 19));
        end
        waitDrain(100, drained);
        nCompared++;
        if (!drained || (outBeats - base) != 20) begin
            nMismatched++;
            $display("[TB] FAIL oversize_beats: got %0d beats drained %b expected 20 drained 1", outBeats - base, drained);
        end
    endtask

    task automatic test_back_to_back_bp_in();
        int  base;
        bit  drained;
        stream_out_TREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h3000_0000 + i, 4'hF, (i == 3));
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(32'h3100_0000 + i, (i == 1) ? 4'h7 : 4'hF, (i == 1));
        end
        base = outBeats;
        stream_out_TREADY = 1'b1;
        for (int c = 0; c < 20 && (outBeats - base) < 1; c++) begin
            @(posedge clk_line);
            #1;
        end
        backpressure_in = 1'b1;
        repeat (10) @(posedge clk_line);
        #1;
        nCompared++;
        if ((outBeats - base) != 4 || stream_out_TVALID !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL bp_in_hold: got %0d beats tvalid %b expected 4 beats tvalid 0", outBeats - base, stream_out_TVALID);
        end
        backpressure_in = 1'b0;
        waitDrain(40, drained);
        nCompared++;
        if (!drained || (outBeats - base) != 6) begin
            nMismatched++;
            $display("[TB] FAIL bp_in_release: got %0d beats expected 6", outBeats - base);
        end
    endtask

    task automatic test_protocol_err();
        bit drained;
        stream_out_TREADY = 1'b1;
        nCompared++;
        if (protocol_err !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL err_before: got %b expected 0", protocol_err);
        end
        applyStimulus(32'hDEAD_BEEF, 4'h7, 1'b0);
        nCompared++;
        if (protocol_err !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL err_set: got %b expected 1", protocol_err);
        end
        applyStimulus(32'h0BAD_F00D, 4'hF, 1'b1);
        waitDrain(40, drained);
        nCompared++;
        if (!drained || protocol_err !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL err_sticky: got err %b drained %b expected err 1 drained 1", protocol_err, drained);
        end
    endtask

    task automatic test_reset_mid_packet();
        int base;
        bit drained;
        stream_out_TREADY = 1'b1;
        applyStimulus(32'h4000_0000, 4'hF, 1'b0);
        applyStimulus(32'h4000_0001, 4'hF, 1'b0);
        doReset();
        nCompared++;
        if (stream_out_TVALID !== 1'b0 || stream_in_TREADY !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL midrst_outputs: got tvalid %b tready %b expected tvalid 0 tready 1", stream_out_TVALID, stream_in_TREADY);
        end
        nCompared++;
        if (protocol_err !== 1'b0 || backpressure_out !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_flags: got err %b bp %b expected err 0 bp 0", protocol_err, backpressure_out);
        end
        base = outBeats;
        applyStimulus(32'h5555_AAAA, 4'h1, 1'b1);
        waitDrain(40, drained);
        nCompared++;
        if (!drained || (outBeats - base) != 1) begin
            nMismatched++;
            $display("[TB] FAIL midrst_fresh: got %0d beats expected 1", outBeats - base);
        end
    endtask

    initial begin
        $display("[TB] starting s_protocol_adapter_egress bench");
        test_reset();
        test_store_fwd();
        test_backpressure_fill();
        test_oversize();
        test_back_to_back_bp_in();
        test_protocol_err();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
